// File: rtl/bias_add_sequencer.sv
// Bias-add sequencer: walks the per-group bias banks and adds the latched bias lane-wise,
// with saturation, to every accumulator beat. Optional fused ReLU when BIAS_RELU_EN is defined.
module bias_add_sequencer #(
   parameter int N_adder_tree  = 16,
   parameter int DATA_W        = 18,
   parameter int NUM_GROUPS    = 4,
   parameter int PIX_PER_GROUP = 196,
   localparam int SEL_W        = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic [SEL_W-1:0]                 bias_sel,
   input  logic [N_adder_tree*DATA_W-1:0]   bias_q,
   input  logic                             acc_valid,
   output logic                             acc_ready,
   input  logic [N_adder_tree*DATA_W-1:0]   acc_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [N_adder_tree*DATA_W-1:0]   out_data,
   output logic [SEL_W-1:0]                 out_group
);

   localparam int PIX_W = (PIX_PER_GROUP > 1) ? $clog2(PIX_PER_GROUP) : 1;
   localparam int VEC_W = N_adder_tree * DATA_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LATCH,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  group_q, group_d;
   logic [PIX_W-1:0]  pix_q, pix_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [VEC_W-1:0]  bias_reg_q, bias_reg_d;
   logic              out_valid_q, out_valid_d;
   logic [VEC_W-1:0]  out_data_q, out_data_d;
   logic [SEL_W-1:0]  out_group_q, out_group_d;
   logic [VEC_W-1:0]  sum_vec;
   logic              last_pix, last_group, acc_fire;

   function automatic logic [DATA_W-1:0] lane_op(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic [DATA_W:0]   s;
      logic [DATA_W-1:0] r;
      s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
      // Overflow when the extra sign bit disagrees with the lane sign bit.
      if (s[DATA_W] != s[DATA_W-1]) begin
         r = s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
         r = s[DATA_W-1:0];
      end
`ifdef BIAS_RELU_EN
      if (r[DATA_W-1]) begin
         r = '0;
      end
`endif
      return r;
   endfunction

   always_comb begin
      sum_vec = '0;
      for (int unsigned i = 0; i < N_adder_tree; i++) begin
         sum_vec[i*DATA_W +: DATA_W] = lane_op(acc_data[i*DATA_W +: DATA_W],
                                               bias_reg_q[i*DATA_W +: DATA_W]);
      end
   end

   assign last_pix   = (pix_q == PIX_W'(PIX_PER_GROUP - 1));
   assign last_group = (group_q == SEL_W'(NUM_GROUPS - 1));
   assign acc_fire   = acc_valid && acc_ready;

   always_comb begin
      state_d    = state_q;
      group_d    = group_q;
      pix_d      = pix_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      bias_reg_d = bias_reg_q;
      acc_ready  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               group_d = '0;
               pix_d   = '0;
               busy_d  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LATCH;
         end
         S_LATCH: begin
            bias_reg_d = bias_q;
            state_d    = S_RUN;
         end
         S_RUN: begin
            acc_ready = !out_valid_q || out_ready;
            if (acc_valid && acc_ready) begin
               if (last_pix) begin
                  pix_d = '0;
                  if (last_group) begin
                     state_d = S_DRAIN;
                  end else begin
                     group_d = group_q + SEL_W'(1);
                     state_d = S_FETCH;
                  end
               end else begin
                  pix_d = pix_q + PIX_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (!out_valid_q || out_ready) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // One-deep output register: a take and a new load in the same cycle keep valid high.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_group_d = out_group_q;
      if (acc_fire) begin
         out_valid_d = 1'b1;
         out_data_d  = sum_vec;
         out_group_d = group_q;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         group_q     <= '0;
         pix_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         bias_reg_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_group_q <= '0;
      end else begin
         state_q     <= state_d;
         group_q     <= group_d;
         pix_q       <= pix_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         bias_reg_q  <= bias_reg_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_group_q <= out_group_d;
      end
   end

   // The group register doubles as the bank select, so the bank mux sees the new
   // index on the same edge that enters FETCH.
   assign bias_sel  = group_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_group = out_group_q;

endmodule
